// File: rtl/i2c_delay_timer_pkg.sv
// Shared definitions for the programmable I2C delay timer: channel states,
// standard-mode I2C tick counts at 50 MHz and the start-load helper.
package i2c_delay_timer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // 100 kHz standard-mode bus timings expressed in 20 ns clock periods
  localparam int unsigned T_HD_STA = 32'd200;
  localparam int unsigned T_LOW    = 32'd235;
  localparam int unsigned T_HIGH   = 32'd200;
  localparam int unsigned T_SU_STO = 32'd200;
  localparam int unsigned T_BUF    = 32'd235;

  // max(n,1)-1: a zero-length request behaves like a one-cycle delay
  function automatic logic [31:0] load_value(input logic [31:0] n);
    if (n == 32'd0) begin
      return 32'd0;
    end else begin
      return n - 32'd1;
    end
  endfunction

endpackage

// File: rtl/i2c_delay_timer_ch.sv
// Single timer channel: IDLE/RUN FSM around a down-counter that raises a
// registered one-cycle done pulse N clocks after start.
module i2c_delay_timer_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             periodic,
  input  logic [CNT_W-1:0] ticks,
  output logic             busy,
  output logic             done
);
  import i2c_delay_timer_pkg::*;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] reload_r, reload_s;
  logic             mode_r, mode_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [CNT_W-1:0] load_s;

  // next-state logic: abort beats start, start beats counting
  always_comb begin
    load_s   = CNT_W'(load_value(32'(ticks)));
    state_s  = state_r;
    cnt_s    = cnt_r;
    reload_s = reload_r;
    mode_s   = mode_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    if (abort) begin
      state_s = ST_IDLE;
      cnt_s   = '0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
    end else begin
      // an expiring run still reports done even if a retrigger lands on it
      if ((state_r == ST_RUN) && (cnt_r == '0)) begin
        done_s = 1'b1;
      end else begin
        done_s = 1'b0;
      end
      if (start) begin
        reload_s = load_s;
        cnt_s    = load_s;
        mode_s   = periodic;
        state_s  = ST_RUN;
        busy_s   = 1'b1;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (cnt_r != '0) begin
              cnt_s = cnt_r - CNT_W'(1'b1);
            end else if (mode_r) begin
              cnt_s = reload_r;
            end else begin
              state_s = ST_IDLE;
              busy_s  = 1'b0;
            end
          end
          ST_IDLE: begin
            state_s = ST_IDLE;
          end
          default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            busy_s  = 1'b0;
          end
        endcase
      end
    end
  end

  // channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      reload_r <= '0;
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      reload_r <= reload_s;
      mode_r   <= mode_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: rtl/i2c_delay_timer.sv
// Multi-channel runtime-programmable cycle timer used by the I2C bit/byte
// controller for bus timing; channels are independent instances.
module i2c_delay_timer #(
  parameter int CNT_W  = 16,
  parameter int NUM_CH = 4
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] ticks,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);
  import i2c_delay_timer_pkg::*;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    i2c_delay_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (CLK),
      .rst_n    (rst_n),
      .start    (start[c]),
      .abort    (abort[c]),
      .periodic (periodic[c]),
      .ticks    (ticks[c*CNT_W +: CNT_W]),
      .busy     (busy[c]),
      .done     (done[c])
    );
  end

endmodule

// File: tb/tb_i2c_delay_timer.sv
// Directed self-checking bench for i2c_delay_timer; k counts edges after the
// start-sampling edge E0, outputs are sampled 1 ns after each edge.
module tb_i2c_delay_timer;
  import i2c_delay_timer_pkg::*;

  localparam int CNT_W  = 16;
  localparam int NUM_CH = 4;

  logic                    CLK;
  logic                    rst_n;
  logic [NUM_CH-1:0]       start, abort, periodic, busy, done;
  logic [NUM_CH*CNT_W-1:0] ticks;
  int checks = 0;
  int errors = 0;

  i2c_delay_timer #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .abort(abort),
    .periodic(periodic), .ticks(ticks), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ticks(input int c, input int n);
    ticks[c*CNT_W +: CNT_W] = n[CNT_W-1:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = '0; abort = '0; periodic = '0; ticks = '0;
    tick(); tick();
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy got %b exp 0000", busy); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b exp 0000", done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_one_shot();
    set_ticks(0, 20); periodic[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k <= 22; k++) begin
      checks++; if (busy[0] !== (k < 20)) begin errors++; $display("FAIL one_shot_busy k=%0d got %b exp %b", k, busy[0], (k < 20)); end
      checks++; if (done[0] !== (k == 20)) begin errors++; $display("FAIL one_shot_done k=%0d got %b exp %b", k, done[0], (k == 20)); end
      checks++; if (busy[3:1] !== 3'b000) begin errors++; $display("FAIL one_shot_xtalk k=%0d got %b exp 000", k, busy[3:1]); end
      tick();
    end
  endtask

  task automatic test_periodic_abort();
    set_ticks(1, 5); periodic[1] = 1'b1; start[1] = 1'b1;
    tick();
    start[1] = 1'b0; periodic[1] = 1'b0; set_ticks(1, 9);
    for (int k = 0; k <= 22; k++) begin
      checks++; if (busy[1] !== (k < 17)) begin errors++; $display("FAIL periodic_busy k=%0d got %b exp %b", k, busy[1], (k < 17)); end
      checks++; if (done[1] !== (k == 5 || k == 10 || k == 15)) begin errors++; $display("FAIL periodic_done k=%0d got %b exp %b", k, done[1], (k == 5 || k == 10 || k == 15)); end
      if (k == 16) abort[1] = 1'b1;
      if (k == 17) abort[1] = 1'b0;
      tick();
    end
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    checks++; if ({busy[1], done[1]} !== 2'b00) begin errors++; $display("FAIL abort_idle got %b exp 00", {busy[1], done[1]}); end
  endtask

  task automatic test_short();
    for (int n = 0; n <= 1; n++) begin
      set_ticks(3, n); periodic[3] = 1'b0; start[3] = 1'b1;
      tick();
      start[3] = 1'b0;
      for (int k = 0; k <= 3; k++) begin
        checks++; if (busy[3] !== (k == 0)) begin errors++; $display("FAIL short_busy n=%0d k=%0d got %b exp %b", n, k, busy[3], (k == 0)); end
        checks++; if (done[3] !== (k == 1)) begin errors++; $display("FAIL short_done n=%0d k=%0d got %b exp %b", n, k, done[3], (k == 1)); end
        tick();
      end
    end
  endtask

  task automatic test_max();
    int first_done = -1;
    int first_idle = -1;
    int pulses = 0;
    set_ticks(3, 65535); periodic[3] = 1'b0; start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    for (int k = 0; k <= 65540; k++) begin
      if (done[3] === 1'b1) begin
        pulses++;
        if (first_done < 0) first_done = k;
      end
      if (busy[3] !== 1'b1 && first_idle < 0) first_idle = k;
      tick();
    end
    checks++; if (first_done != 65535) begin errors++; $display("FAIL max_done_cycle got %0d exp 65535", first_done); end
    checks++; if (first_idle != 65535) begin errors++; $display("FAIL max_busy_fall got %0d exp 65535", first_idle); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL max_pulse_count got %0d exp 1", pulses); end
  endtask

  task automatic test_retrigger();
    set_ticks(2, 10); periodic[2] = 1'b0; start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      checks++; if (busy[2] !== (k < 9)) begin errors++; $display("FAIL retrig_busy k=%0d got %b exp %b", k, busy[2], (k < 9)); end
      checks++; if (done[2] !== (k == 9)) begin errors++; $display("FAIL retrig_done k=%0d got %b exp %b", k, done[2], (k == 9)); end
      if (k == 5) begin set_ticks(2, 3); start[2] = 1'b1; end
      if (k == 6) start[2] = 1'b0;
      tick();
    end
  endtask

  task automatic test_start_abort();
    set_ticks(2, 4); start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      checks++; if (busy[2] !== (k < 2)) begin errors++; $display("FAIL start_abort_busy k=%0d got %b exp %b", k, busy[2], (k < 2)); end
      checks++; if (done[2] !== 1'b0) begin errors++; $display("FAIL start_abort_done k=%0d got %b exp 0", k, done[2]); end
      if (k == 1) begin set_ticks(2, 2); start[2] = 1'b1; abort[2] = 1'b1; end
      if (k == 2) begin start[2] = 1'b0; abort[2] = 1'b0; end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    set_ticks(0, 3); periodic[0] = 1'b0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      checks++; if (busy[0] !== (k < 7)) begin errors++; $display("FAIL b2b_busy k=%0d got %b exp %b", k, busy[0], (k < 7)); end
      checks++; if (done[0] !== (k == 3 || k == 7)) begin errors++; $display("FAIL b2b_done k=%0d got %b exp %b", k, done[0], (k == 3 || k == 7)); end
      if (k == 2) begin set_ticks(0, 4); start[0] = 1'b1; end
      if (k == 3) start[0] = 1'b0;
      tick();
    end
  endtask

  task automatic test_independence();
    logic [3:0] exp_busy, exp_done;
    set_ticks(0, T_HD_STA); set_ticks(1, T_LOW); set_ticks(2, T_HIGH); set_ticks(3, 7);
    periodic = 4'b1000; start = 4'b1111;
    tick();
    start = 4'b0000;
    for (int k = 0; k <= 240; k++) begin
      exp_busy = {1'b1, (k < int'(T_HIGH)), (k < int'(T_LOW)), (k < int'(T_HD_STA))};
      exp_done = {(k > 0 && k % 7 == 0), (k == int'(T_HIGH)), (k == int'(T_LOW)), (k == int'(T_HD_STA))};
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL indep_busy k=%0d got %b exp %b", k, busy, exp_busy); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL indep_done k=%0d got %b exp %b", k, done, exp_done); end
      tick();
    end
    abort = 4'b1000;
    tick();
    abort = 4'b0000;
  endtask

  task automatic test_reset_midrun();
    int bad = 0;
    set_ticks(0, 10); set_ticks(1, 20); set_ticks(2, T_SU_STO); set_ticks(3, T_BUF);
    periodic = 4'b0000; start = 4'b1111;
    tick();
    start = 4'b0000;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (busy !== 4'b1111) begin errors++; $display("FAIL midrun_busy got %b exp 1111", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done} !== 8'h00) begin errors++; $display("FAIL midrun_async got %b exp 00000000", {busy, done}); end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (busy !== 4'b0000 || done !== 4'b0000) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrun_after_release got %0d active cycles exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic_abort();
    test_short();
    test_retrigger();
    test_start_abort();
    test_back_to_back();
    test_independence();
    test_reset_midrun();
    test_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
